// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Parity bit a correct transmitter sends for the given (zero-padded) data word.
  function automatic logic parity_calc(input logic [8:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~(^data);
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Output-side stream of the UART receiver: head word, tags, valid/ready and fill level.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]         data_out;
  logic                         parity_err_out;
  logic                         frame_err_out;
  logic                         valid_out;
  logic                         ready_in;
  logic [$clog2(FIFO_DEPTH):0]  count_out;

  modport master (
    output data_out, parity_err_out, frame_err_out, valid_out, count_out,
    input  ready_in
  );

  modport slave (
    input  data_out, parity_err_out, frame_err_out, valid_out, count_out,
    output ready_in
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is presented whenever non-empty, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with false-start rejection, parity/framing tags,
// break suppression and an output FIFO with sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rx_in,
  uart_rx_fifo_if.master    rx_bus,
  output logic              overflow_out,
  input  logic              clear_err_in
);
  localparam int BW = $clog2(CLOCKS_PER_BAUD);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] HALF_LOAD = BW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(CLOCKS_PER_BAUD - 1);

  logic                 rx_meta, rx_s;
  uart_rx_state_t       state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 push_q, push_n;
  logic                 expire;

  logic [DATA_BITS+1:0] head;
  logic                 fifo_empty, fifo_full, pop;
  logic [CW-1:0]        fifo_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      rx_meta  <= rx_in;
      rx_s     <= rx_meta;
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      push_q   <= push_n;
    end
  end

  assign expire = (baud_cnt == '0);

  always_comb begin
    state_n = state;
    baud_n  = expire ? '0 : baud_cnt - BW'(1);
    bit_n   = bit_cnt;
    shift_n = shift_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    push_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        bit_n = '0;
        if (!rx_s) begin
          state_n = ST_START;
          baud_n  = HALF_LOAD;
        end
      end
      ST_START: if (expire) begin
        if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DATA;
          baud_n  = FULL_LOAD;
          bit_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_DATA: if (expire) begin
        shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
        baud_n  = FULL_LOAD;
        if (bit_cnt == 4'(DATA_BITS - 1)) begin
          bit_n   = '0;
          state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          bit_n = bit_cnt + 4'd1;
        end
      end
      ST_PARITY: if (expire) begin
        perr_n  = rx_s ^ parity_calc(9'(shift_q), PARITY);
        baud_n  = FULL_LOAD;
        state_n = ST_STOP;
      end
      ST_STOP: if (expire) begin
        if (!rx_s) ferr_n = 1'b1;
        if (bit_cnt == 4'(STOP_BITS - 1)) begin
          // Leave at mid-stop so the next start edge is caught half a bit early.
          push_n  = 1'b1;
          bit_n   = '0;
          state_n = (ferr_q || !rx_s) ? ST_BREAK : ST_IDLE;
        end else begin
          bit_n  = bit_cnt + 4'd1;
          baud_n = FULL_LOAD;
        end
      end
      ST_BREAK: if (rx_s) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign pop = !fifo_empty && rx_bus.ready_in;

  sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push_q),
    .wr_data ({ferr_q, perr_q, shift_q}),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign rx_bus.data_out       = head[DATA_BITS-1:0];
  assign rx_bus.parity_err_out = head[DATA_BITS];
  assign rx_bus.frame_err_out  = head[DATA_BITS+1];
  assign rx_bus.valid_out      = !fifo_empty;
  assign rx_bus.count_out      = fifo_count;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_in) begin
    if (rst_in)                          overflow_out <= 1'b0;
    else if (push_q && fifo_full && !pop) overflow_out <= 1'b1;
    else if (clear_err_in)               overflow_out <= 1'b0;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver: next generation of the single-byte LiDAR/IMU receivers in top_level.
- Configurable data width, parity mode and stop-bit count.
- Metastability synchroniser, false-start rejection, per-word parity/framing error tags.
- Buffers received words in an internal FIFO with valid/ready output and a sticky overflow flag.
- One instance per serial sensor port (pmoda/pmodb) feeding downstream parsers.

Parameters:
- CLOCKS_PER_BAUD, 868, clk_in cycles per bit (100 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, word capacity; power of two, >= 2.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  head-of-FIFO data word.
- parity_err_out  output  1  head word failed its parity check (0 when PARITY = 0).
- frame_err_out  output  1  head word had a low stop bit.
- valid_out  output  1  FIFO non-empty.
- ready_in  input  1  consumer accepts the head word.
- count_out  output  $clog2(FIFO_DEPTH)+1  words held.
- overflow_out  output  1  sticky: a word was dropped because the FIFO was full.
- clear_err_in  input  1  clears overflow_out.

Behaviour:
- Reset (synchronous, active-high on clk_in):
  - FSM returns to IDLE; bit and baud counters = 0.
  - Both synchroniser flops = 1.
  - FIFO emptied: valid_out = 0, count_out = 0, data_out = 0, both error tags = 0.
  - overflow_out = 0.
  - Reset mid-frame abandons the partial word; nothing is pushed.
- Synchroniser: 2 flops; rx_s is the second flop output. Internal latency 2 cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s == 0 → START, baud counter loads CLOCKS_PER_BAUD/2 - 1.
- START: on counter expiry, sample rx_s (mid start bit).
  - rx_s == 1 → false start, back to IDLE, no push.
  - rx_s == 0 → DATA, counter loads CLOCKS_PER_BAUD - 1.
- DATA: sample at each expiry; LSB first into a shift register.
  - After DATA_BITS samples → PARITY if PARITY != 0, else STOP.
- PARITY: sample one bit.
  - Error when XOR(data, parity bit) == 0 for odd, or == 1 for even.
- STOP: sample STOP_BITS bits, each one baud apart.
  - Any stop sample == 0 sets the frame error tag.
  - After the last stop sample, push {frame_err, parity_err, data} into the FIFO on the next cycle.
  - Next state: IDLE if no frame error, else BREAK.
  - IDLE is re-entered at mid-stop-bit, so a following start edge is tracked from half a bit early.
- BREAK: wait until rx_s == 1, then IDLE. A held-low line yields exactly one word (tagged frame_err), not a stream.
- FIFO (sync_fifo):
  - Show-ahead: data_out and tags present the head whenever valid_out = 1.
  - Pop when valid_out && ready_in; head advances the next cycle.
  - valid_out rises the cycle after the push cycle.
- Push while full:
  - Without a simultaneous pop: word dropped, overflow_out set.
  - With a simultaneous pop: push accepted, count unchanged, no overflow.
- Push and pop when empty: no bypass; word stored, valid_out next cycle.
- Pointers wrap modulo FIFO_DEPTH; count_out saturates at FIFO_DEPTH by construction.
- overflow_out:
  - Cleared by clear_err_in.
  - If a drop and clear_err_in occur in the same cycle, set wins.
- ready_in with valid_out = 0 is ignored.

Decomposition:
- Package uart_pkg:
  - FSM state enum (uart_rx_state_t).
  - Parity constants PARITY_NONE/ODD/EVEN.
  - Function parity_calc(data, mode).
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports clk_in, rst_in, push, wr_data, pop, rd_data, empty, full, count.
  - Instantiated with WIDTH = DATA_BITS+2.

Test Plan:
- 8N1, CLOCKS_PER_BAUD = 16: send 0xA5, ready_in = 0 → valid_out = 1, data_out = 0xA5, tags 0, count_out = 1. Pulse ready_in → count_out = 0.
- Even parity, 8E1: send 0x03 with parity bit 0 → tags 0. Send 0x03 with parity bit 1 → parity_err_out = 1. Odd mode (PARITY = 1), same 0x03 with parity bit 0 → parity_err_out = 1.
- Glitch: rx_in low for 5 cycles (< 8) → no word, FSM back in IDLE. Hold rx_in low for 20 bit times → exactly one word 0x00 with frame_err_out = 1; next 0x5A after line release received cleanly.
- Overflow, FIFO_DEPTH = 4: send 0x11..0x15 back-to-back, ready_in = 0 → count_out = 4, overflow_out = 1. Drain yields 0x11, 0x12, 0x13, 0x14. clear_err_in → overflow_out = 0.
- Full FIFO with ready_in held 1 during the push cycle of a 5th word → word accepted, count_out stays 4, overflow_out stays 0.
- Reset mid-frame: assert rst_in during bit 4 of 0xFF → count_out = 0, no push. Next frame 0x3C received correctly. 7O2 config sending 0x7F → data_out = 0x7F, tags 0.
